// File: rtl/wb_mem_stage.sv
// Write-back / memory stage: retires instructions from execute, runs one
// data-memory load or store at a time over a req/gnt/rvalid bus, extends
// load data and drives the register-file write port and forwarding view.
module wb_mem_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [1:0]      ex_size,
  input  logic            ex_unsigned,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_store_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [RA_W-1:0] rd,
  output logic [XLEN-1:0] wd,
  output logic            reg_write,
  output logic            fwd_valid,
  output logic [RA_W-1:0] fwd_rd
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            reg_write_q, reg_write_d;
  logic            we_q, we_d;          // effective write enable of the captured load
  logic            is_load_q, is_load_d;
  logic            is_store_q, is_store_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [1:0]      off_q, off_d;        // byte offset inside the word
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] load_val;

  // Select the addressed lane of the returned word and extend it.
  always_comb begin
    lane_b = mem_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_val = uns_q ? {{(XLEN-8){1'b0}}, lane_b}
                                : {{(XLEN-8){lane_b[7]}}, lane_b};
      2'b01:   load_val = uns_q ? {{(XLEN-16){1'b0}}, lane_h}
                                : {{(XLEN-16){lane_h[15]}}, lane_h};
      default: load_val = mem_rdata;
    endcase
  end

  // Next-state logic: accept from execute, sequence the memory bus, retire.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    rd_d        = rd_q;
    wd_d        = wd_q;
    reg_write_d = 1'b0;                 // write enable is a single-cycle pulse
    we_d        = we_q;
    is_load_d   = is_load_q;
    is_store_d  = is_store_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          rd_d = ex_rd;
          if (ex_mem_read || ex_mem_write) begin
            we_d        = ex_reg_write && (ex_rd != '0) && ex_mem_read;
            is_load_d   = ex_mem_read;
            is_store_d  = ex_mem_write;
            size_d      = ex_size;
            uns_d       = ex_unsigned;
            off_d       = ex_result[1:0];
            mem_addr_d  = {ex_result[XLEN-1:2], 2'b00};
            case (ex_size)
              2'b00: begin
                mem_be_d    = 4'b0001 << ex_result[1:0];
                mem_wdata_d = {(XLEN/8){ex_store_data[7:0]}};
              end
              2'b01: begin
                mem_be_d    = ex_result[1] ? 4'b1100 : 4'b0011;
                mem_wdata_d = {(XLEN/16){ex_store_data[15:0]}};
              end
              default: begin
                mem_be_d    = 4'b1111;
                mem_wdata_d = ex_store_data;
              end
            endcase
            state_d = S_REQ;
          end else begin
            wd_d        = ex_result;
            reg_write_d = ex_reg_write && (ex_rd != '0);
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = is_store_q ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (mem_rvalid) begin
          wd_d        = load_val;
          reg_write_d = we_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_q        <= '0;
      wd_q        <= '0;
      reg_write_q <= 1'b0;
      we_q        <= 1'b0;
      is_load_q   <= 1'b0;
      is_store_q  <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      rd_q        <= rd_d;
      wd_q        <= wd_d;
      reg_write_q <= reg_write_d;
      we_q        <= we_d;
      is_load_q   <= is_load_d;
      is_store_q  <= is_store_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ex_ready  = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = (state_q == S_REQ) && is_store_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rd        = rd_q;
  assign wd        = wd_q;
  assign reg_write = reg_write_q;
  assign fwd_valid = reg_write_q || ((state_q != S_IDLE) && is_load_q && we_q);
  assign fwd_rd    = rd_q;

endmodule

// File: doc/wb_mem_stage.md
Name: wb_mem_stage

Overview:
Final pipeline stage and sole driver of the register-file write port (rd, wd, reg_write). Accepts retiring instructions from the execute stage over a valid/ready handshake, performs data-memory loads and stores over a req/gnt/rvalid bus, and sign- or zero-extends load data. Issues exactly one register write per writing instruction and exports a forwarding view of the pending write.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute stage presents an instruction
ex_ready  out  1  stage can accept this cycle
ex_rd  in  RA_W  destination register
ex_reg_write  in  1  instruction writes rd
ex_mem_read  in  1  load
ex_mem_write  in  1  store (mutually exclusive with load)
ex_size  in  2  00 byte, 01 half, 10 word
ex_unsigned  in  1  zero-extend load
ex_result  in  XLEN  ALU result / memory address
ex_store_data  in  XLEN  store data, right-aligned
mem_req  out  1  memory request
mem_we  out  1  store request
mem_addr  out  XLEN  word-aligned address
mem_be  out  4  byte enables
mem_wdata  out  XLEN  lane-replicated store data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  load data valid
mem_rdata  in  XLEN  load word
rd  out  RA_W  register-file write address
wd  out  XLEN  register-file write data
reg_write  out  1  register-file write enable, one-cycle pulse
fwd_valid  out  1  write in flight (load pending or reg_write high)
fwd_rd  out  RA_W  register of that write

Behaviour:
- Reset (async, rst_n low): state IDLE. reg_write=0, mem_req=0, mem_we=0, fwd_valid=0. rd, wd, mem_addr, mem_wdata, mem_be and fwd_rd are 0. ex_ready=1 after release. A transaction in progress is abandoned: mem_req drops immediately, and no write occurs for it.
- Write-enable gating: the effective write enable is ex_reg_write && ex_rd!=0. When rd is 0, reg_write and fwd_valid are never raised.
- States: IDLE, REQ, RESP.
- IDLE: ex_ready=1. Transfer happens on ex_valid&&ex_ready at a rising edge.
  - Non-memory instruction: at that edge rd<=ex_rd, wd<=ex_result, and reg_write<=effective enable. Latency is one cycle; the register file writes on the next edge.
  - Load or store: capture all fields and go to REQ.
  - Back-to-back ALU transfers are allowed every cycle.
  - reg_write otherwise clears each cycle.
- REQ: ex_ready=0 and mem_req=1. mem_we=store. mem_addr={addr[XLEN-1:2],2'b00}. mem_be, mem_addr and mem_wdata stay stable until mem_gnt.
  - Byte: be=1<<addr[1:0], wdata=data[7:0] replicated ×4.
  - Half: be=addr[1]?1100:0011, wdata=data[15:0] replicated ×2.
  - Word: be=1111.
  - On gnt: store goes to IDLE with no register write; load goes to RESP and mem_req drops.
- RESP: ex_ready=0 and mem_req=0. mem_rvalid is sampled only in RESP and ignored elsewhere. On rvalid, select a lane using addr[1:0] (byte) or addr[1] (half), then extend: zero-extend when ex_unsigned, sign-extend otherwise. Set wd to the result, reg_write to the effective enable, and go to IDLE. The load write therefore lands one cycle after rvalid.
- Misaligned half-word access (addr[0]=1): the stage uses addr[1] only. Word access ignores addr[1:0]. No trap is raised.
- Forwarding: fwd_valid=1 in the cycle reg_write is high, and in REQ/RESP for a load with the effective enable set. fwd_rd is the captured rd. The hazard unit stalls on a match while in REQ/RESP.
- Only one outstanding memory transaction is allowed; ex_ready=0 guarantees this.

Test Plan:
- Reset mid-load: assert rst_n=0 while in RESP, then return rvalid=1 -> reg_write stays 0, mem_req=0, state IDLE, ex_ready=1.
- Three back-to-back ALU ops (rd=1,2,3; results 0x11,0x22,0x33), one per cycle -> reg_write high for three consecutive cycles with matching rd/wd. ex_ready never drops.
- ALU op with rd=0, reg_write=1, result 0xDEAD -> reg_write and fwd_valid remain 0.
- Signed byte load at addr 0x1003, gnt delayed 2 cycles, rdata 0x80FF_0000 -> mem_req held 3 cycles with addr 0x1000 and be 1000. wd=0xFFFF_FF80 and reg_write pulses one cycle after rvalid.
- Unsigned half load at addr 0x2002, rdata 0x8001_1234 -> wd=0x0000_8001. The same load signed -> wd=0xFFFF_8001.
- Half store of 0xABCD at 0x3002 -> mem_we=1, be=1100, wdata=0xABCD_ABCD. No reg_write, and the stage returns to IDLE the cycle after gnt.
